// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern transmitter: sends pattern[length-1:0] MSB first on w_out,
// one bit per enabled clock, once or looping, with registered status outputs.
module serial_pattern_gen #(
   parameter int MAX_LEN = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [MAX_LEN-1:0]           pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0] length,
   input  logic                         repeat_en,
   input  logic                         enable,
   input  logic                         abort,
   output logic                         w_out,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(MAX_LEN+1)-1:0] bits_left,
   output logic [1:0]                   state
);

   localparam int LW = $clog2(MAX_LEN+1);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] SHIFT = 2'b01;
   localparam logic [1:0] DONE  = 2'b10;

   logic [1:0]         state_q,   state_d;
   logic [MAX_LEN-1:0] shreg_q,   shreg_d;
   logic [MAX_LEN-1:0] pat_cap_q, pat_cap_d;
   logic [LW-1:0]      len_cap_q, len_cap_d;
   logic [LW-1:0]      cnt_q,     cnt_d;
   logic               w_out_q,   w_out_d;
   logic               busy_q,    busy_d;
   logic               done_q,    done_d;

   logic [LW-1:0]      len_eff;
   logic [LW-1:0]      shamt;
   logic [MAX_LEN-1:0] pat_aligned;

   // Left-align the field so the current bit is always shreg[MAX_LEN-1];
   // bits above length-1 fall off the top and never reach the line.
   always_comb begin
      len_eff     = (length > LW'(MAX_LEN)) ? LW'(MAX_LEN) : length;
      shamt       = LW'(MAX_LEN) - len_eff;
      pat_aligned = pattern << shamt;
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      pat_cap_d = pat_cap_q;
      len_cap_d = len_cap_q;
      cnt_d     = cnt_q;

      case (state_q)
         IDLE: begin
            if (start && (length != '0)) begin
               shreg_d   = pat_aligned;
               pat_cap_d = pat_aligned;
               len_cap_d = len_eff;
               cnt_d     = len_eff;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (enable) begin
               if (cnt_q > LW'(1)) begin
                  shreg_d = shreg_q << 1;
                  cnt_d   = cnt_q - LW'(1);
               end else if (repeat_en) begin
                  shreg_d = pat_cap_q;
                  cnt_d   = len_cap_q;
               end else begin
                  shreg_d = '0;
                  cnt_d   = '0;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            shreg_d   = '0;
            pat_cap_d = '0;
            len_cap_d = '0;
            cnt_d     = '0;
            state_d   = IDLE;
         end
      endcase

      if (abort) begin
         shreg_d = '0;
         cnt_d   = '0;
         state_d = IDLE;
      end

      // Outputs are decoded from next state so they land in flops.
      w_out_d = (state_d == SHIFT) ? shreg_d[MAX_LEN-1] : 1'b0;
      busy_d  = (state_d == SHIFT);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         pat_cap_q <= '0;
         len_cap_q <= '0;
         cnt_q     <= '0;
         w_out_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         pat_cap_q <= pat_cap_d;
         len_cap_q <= len_cap_d;
         cnt_q     <= cnt_d;
         w_out_q   <= w_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign w_out     = w_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign bits_left = cnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: directed vector table, hand-written repeat and
// clamp sequences, then random stimulus against a bit-index reference model.
module tb_serial_pattern_gen;

   localparam int MAX_LEN = 16;
   localparam int LW      = 5;

   logic            clock, reset, start, repeat_en, enable, abort;
   logic [15:0]     pattern;
   logic [LW-1:0]   length;
   logic            w_out, busy, done;
   logic [LW-1:0]   bits_left;
   logic [1:0]      state;

   int errors = 0;
   int checks = 0;

   serial_pattern_gen #(.MAX_LEN(MAX_LEN)) dut (
      .clock(clock), .reset(reset), .start(start), .pattern(pattern),
      .length(length), .repeat_en(repeat_en), .enable(enable), .abort(abort),
      .w_out(w_out), .busy(busy), .done(done), .bits_left(bits_left),
      .state(state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic          rst, st;
      logic [15:0]   pat;
      logic [LW-1:0] len;
      logic          rep, en, ab;
      logic          w, bsy, dn;
      logic [LW-1:0] bl;
      logic [1:0]    stt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic rst, st, input logic [15:0] pat,
                              input logic [LW-1:0] len, input logic rep, en, ab,
                              input logic w, bsy, dn, input logic [LW-1:0] bl,
                              input logic [1:0] stt);
      vec_t r;
      r.rst = rst; r.st = st; r.pat = pat; r.len = len; r.rep = rep;
      r.en = en; r.ab = ab; r.w = w; r.bsy = bsy; r.dn = dn; r.bl = bl; r.stt = stt;
      return r;
   endfunction

   // Reference model: mode 0 idle, 1 sending bit index m_i of m_n, 2 done.
   int          m_mode = 0;
   logic [15:0] m_p    = '0;
   int          m_n    = 0;
   int          m_i    = 0;

   task automatic model_step(input logic rst, st, input logic [15:0] pat,
                             input logic [LW-1:0] len, input logic rep, en, ab);
      if (rst || ab) begin
         m_mode = 0;
      end else if (m_mode == 0) begin
         if (st && len != 0) begin
            m_n    = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
            m_p    = pat;
            m_i    = 0;
            m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (en) begin
            if (m_i + 1 < m_n)  m_i = m_i + 1;
            else if (rep)       m_i = 0;
            else                m_mode = 2;
         end
      end else begin
         m_mode = 0;
      end
   endtask

   function automatic logic [9:0] model_out();
      logic          w;
      logic [LW-1:0] bl;
      w  = (m_mode == 1) ? m_p[m_n - 1 - m_i] : 1'b0;
      bl = (m_mode == 1) ? LW'(m_n - m_i) : '0;
      return {w, 1'(m_mode == 1), 1'(m_mode == 2), bl, 2'(m_mode)};
   endfunction

   task automatic apply(input logic rst, st, input logic [15:0] pat,
                        input logic [LW-1:0] len, input logic rep, en, ab);
      reset = rst; start = st; pattern = pat; length = len;
      repeat_en = rep; enable = en; abort = ab;
      @(posedge clock);
      #1;
      model_step(rst, st, pat, len, rep, en, ab);
   endtask

   task automatic chk(input string name, input logic [9:0] exp);
      logic [9:0] act;
      act = {w_out, busy, done, bits_left, state};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got w=%b busy=%b done=%b bits_left=%0d state=%b, want w=%b busy=%b done=%b bits_left=%0d state=%b",
                  name, act[9], act[8], act[7], act[6:2], act[1:0],
                  exp[9], exp[8], exp[7], exp[6:2], exp[1:0]);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; pattern = '0; length = '0;
      repeat_en = 1'b0; enable = 1'b0; abort = 1'b0;

      // reset state
      tbl.push_back(v(1,0,16'h0000,0,0,0,0, 0,0,0,0,2'b00));
      // single pass 1101
      tbl.push_back(v(0,1,16'h000D,4,0,1,0, 1,1,0,4,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,1,0, 1,1,0,3,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,1,0, 0,1,0,2,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,1,0, 1,1,0,1,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,1,0, 0,0,1,0,2'b10));
      tbl.push_back(v(0,0,16'h000D,4,0,1,0, 0,0,0,0,2'b00));
      // enable every other cycle: 1,1,1,1,0,0,1,1
      tbl.push_back(v(0,1,16'h000D,4,0,0,0, 1,1,0,4,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,0,0, 1,1,0,4,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,1,0, 1,1,0,3,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,0,0, 1,1,0,3,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,1,0, 0,1,0,2,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,0,0, 0,1,0,2,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,1,0, 1,1,0,1,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,0,0, 1,1,0,1,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,1,0, 0,0,1,0,2'b10));
      tbl.push_back(v(0,0,16'h000D,4,0,0,0, 0,0,0,0,2'b00));
      // length 0 ignored
      tbl.push_back(v(0,1,16'hFFFF,0,0,1,0, 0,0,0,0,2'b00));
      // length 1
      tbl.push_back(v(0,1,16'h0001,1,0,1,0, 1,1,0,1,2'b01));
      tbl.push_back(v(0,0,16'h0001,1,0,1,0, 0,0,1,0,2'b10));
      tbl.push_back(v(0,0,16'h0001,1,0,1,0, 0,0,0,0,2'b00));
      // start re-pulsed mid-shift with new pattern/length, then abort on 2nd bit
      tbl.push_back(v(0,1,16'h000D,4,0,1,0, 1,1,0,4,2'b01));
      tbl.push_back(v(0,1,16'h0002,2,0,1,0, 1,1,0,3,2'b01));
      tbl.push_back(v(0,0,16'h000D,4,0,1,1, 0,0,0,0,2'b00));
      tbl.push_back(v(0,0,16'h000D,4,0,1,0, 0,0,0,0,2'b00));
      // reset mid-transmission, and reset together with start
      tbl.push_back(v(0,1,16'h000D,4,0,1,0, 1,1,0,4,2'b01));
      tbl.push_back(v(1,0,16'h000D,4,0,1,0, 0,0,0,0,2'b00));
      tbl.push_back(v(1,1,16'h000D,4,0,1,0, 0,0,0,0,2'b00));
      tbl.push_back(v(0,0,16'h000D,4,0,1,0, 0,0,0,0,2'b00));

      for (int r = 0; r < tbl.size(); r++) begin
         apply(tbl[r].rst, tbl[r].st, tbl[r].pat, tbl[r].len,
               tbl[r].rep, tbl[r].en, tbl[r].ab);
         chk($sformatf("vec%0d", r),
             {tbl[r].w, tbl[r].bsy, tbl[r].dn, tbl[r].bl, tbl[r].stt});
      end

      // repeat 1111: three full passes, drop repeat_en mid fourth pass
      for (int k = 0; k <= 17; k++) begin
         apply(0, (k == 0), 16'h000F, 4, (k <= 13), 1, 0);
         if (k < 16)       chk($sformatf("rep%0d", k), {1'b1, 1'b1, 1'b0, LW'(4 - (k % 4)), 2'b01});
         else if (k == 16) chk("rep_done", {1'b0, 1'b0, 1'b1, LW'(0), 2'b10});
         else              chk("rep_idle", {1'b0, 1'b0, 1'b0, LW'(0), 2'b00});
      end

      // full width 8001, once at length 16 and once clamped from 31
      for (int c = 0; c < 2; c++) begin
         logic [15:0] p;
         p = 16'h8001;
         for (int k = 0; k <= 17; k++) begin
            apply(0, (k == 0), p, (c == 0) ? LW'(16) : LW'(31), 0, 1, 0);
            if (k < 16)       chk($sformatf("len16_%0d_%0d", c, k), {p[15-k], 1'b1, 1'b0, LW'(16 - k), 2'b01});
            else if (k == 16) chk($sformatf("len16_done%0d", c), {1'b0, 1'b0, 1'b1, LW'(0), 2'b10});
            else              chk($sformatf("len16_idle%0d", c), {1'b0, 1'b0, 1'b0, LW'(0), 2'b00});
         end
      end

      // random stimulus against the reference model
      apply(1, 0, 16'h0, 0, 0, 0, 0);
      chk("rand_reset", model_out());
      begin
         logic rep_r;
         rep_r = 1'b0;
         for (int n = 0; n < 3000; n++) begin
            logic          rr, ss, ee, aa;
            logic [15:0]   pp;
            logic [LW-1:0] ll;
            if ($urandom_range(0, 19) == 0) rep_r = ~rep_r;
            rr = ($urandom_range(0, 79) == 0);
            ss = ($urandom_range(0, 3) == 0);
            ee = ($urandom_range(0, 9) < 7);
            aa = ($urandom_range(0, 39) == 0);
            pp = 16'($urandom);
            ll = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 31))
                                             : LW'($urandom_range(1, 8));
            apply(rr, ss, pp, ll, rep_r, ee, aa);
            chk($sformatf("rand%0d", n), model_out());
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
